// File: rtl/elastic_stage_reg.sv
// elastic_stage_reg: inter-stage pipeline register with a valid/ready handshake.
// A 2-entry skid buffer (main + skid) lets in_ready come straight from a
// register, so ready never depends combinationally on downstream signals.
// Stage-specific fields are packed into the opaque payload by the instantiator.
module elastic_stage_reg #(
  parameter int DATA_W        = 72,
  parameter bit ZERO_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The encoding doubles as the occupancy count: EMPTY=0, ONE=1, FULL=2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] main_next;
  logic [DATA_W-1:0] skid_next;
  logic              main_valid;
  logic              skid_valid;
  logic              acc;
  logic              xfer;

  // Both valid bits are decoded from the state register, so every output is
  // a pure function of flops.
  assign main_valid = (state == ONE) || (state == FULL);
  assign skid_valid = (state == FULL);

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Stall is treated exactly like a deasserted out_ready.
  assign acc  = in_valid & in_ready;
  assign xfer = out_valid & out_ready & ~stall;

  // Next-state and payload steering; flush overrides any handshake this cycle.
  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    if (flush) begin
      state_next = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_next  = in_data;
            state_next = ONE;
          end
        end
        ONE: begin
          if (acc && xfer) begin
            main_next = in_data;
          end else if (acc) begin
            skid_next  = in_data;
            state_next = FULL;
          end else if (xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path can fire.
          if (xfer) begin
            main_next  = skid_data;
            state_next = ONE;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers; synchronous reset wins over flush and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_next;
      main_data <= main_next;
      skid_data <= skid_next;
    end
  end

endmodule

// File: doc/elastic_stage_reg.md
Name: elastic_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB). Carries one opaque DATA_W-bit payload bundle between two pipeline stages.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so in_ready is a registered signal and a full-throughput stream can be held without combinational ready paths.
- Keeps the legacy stall input and adds a flush input for branch/hazard squash.
- One instance per stage boundary; stage-specific fields (WB_En, MEM_R_En, dest, PC, ALU_result, …) are concatenated by the instantiating stage.

Parameters:
- DATA_W, 72, payload width in bits; legal range is 1 or more.
- ZERO_ON_FLUSH, 0, when 1, flush also clears both payload registers to 0; when 0, flush clears only the valid bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  legacy hold; while high, no output transfer occurs (acts as out_ready=0).
- flush  in  1  squash; empties the stage on the next edge.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; driven from a register.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of entries held: 0, 1 or 2.

Behaviour:
- Reset (synchronous, active-high): clock is clk; reset is rst, synchronous to clk, active-high. Reset has priority over everything else.
  - Values after the reset edge: main_valid=0, skid_valid=0, main_data=0, skid_data=0.
  - Resulting outputs: out_valid=0, out_data=0, in_ready=1, occupancy=0.
- Definitions:
  - acc = in_valid & in_ready.
  - xfer = out_valid & out_ready & ~stall.
  - out_valid = main_valid; out_data = main_data.
  - in_ready = ~skid_valid.
  - occupancy = main_valid + skid_valid.
- Latency and throughput:
  - An accepted word appears on out_data the cycle after acceptance.
  - One word per cycle is sustained when out_ready=1 and stall=0.
- Update rules when not in reset and flush=0. The states are EMPTY (0), ONE (1) and FULL (2).
  - EMPTY, acc: main <= in_data, main_valid <= 1; go to ONE.
  - ONE, acc & xfer: main <= in_data; stay in ONE.
  - ONE, acc & ~xfer: skid <= in_data, skid_valid <= 1; go to FULL. in_ready drops the following cycle.
  - ONE, ~acc & xfer: main_valid <= 0; go to EMPTY.
  - FULL, xfer: main <= skid, skid_valid <= 0; go to ONE. acc is impossible because in_ready=0.
  - FULL, ~xfer: hold both entries.
  - Any state with neither acc nor xfer: hold.
- Stability: while out_valid=1 and no xfer, out_data is bit-for-bit stable.
- Ordering: strictly FIFO. The skid entry is never presented before the main entry.
- Flush (flush=1, rst=0):
  - Next edge: main_valid <= 0 and skid_valid <= 0. Payloads are zeroed only when ZERO_ON_FLUSH=1.
  - Any acc in the flush cycle is dropped, and so is any xfer. Downstream must qualify xfer with its own flush.
  - The cycle after a flush shows in_ready=1 and out_valid=0.
- Stall: identical to out_ready=0. It does not block acceptance into an empty skid slot.
  - So stall held for 2+ cycles fills the stage to 2 entries, then backpressures upstream.
- Priority: rst > flush > handshake.
- Payload handling: no arithmetic on the payload. Every bit passes unmodified for any DATA_W.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=0, in_ready=1, occupancy=0 during and after the reset.
- Streaming: with out_ready=1 and stall=0, drive in_data 1,2,3,4 on consecutive cycles → out_data shows 1,2,3,4 on cycles +1…+4 with out_valid=1 throughout; in_ready stays 1 and occupancy stays 1.
- Backpressure and drain:
  - Drive words 10, 11, 12 back-to-back with out_ready=0 → 10 held on out_data, occupancy=2, in_ready=0 from cycle 3, and 12 is not accepted.
  - Then raise out_ready → 10, 11, 12 are delivered in order with no loss or duplication.
- Stall equivalence: with out_ready=1 throughout, stall=1 for 3 cycles while streaming 5,6,7 → same result as the backpressure case. After stall drops, out_data goes 5,6,7 in order.
- Flush when full:
  - At occupancy=2 assert flush with in_valid=1, in_data=0x33 → next cycle out_valid=0, occupancy=0, in_ready=1, and 0x33 is never output.
  - Repeat with ZERO_ON_FLUSH=1 → out_data=0.
- Random scoreboard: 10k cycles of random in_valid/out_ready/stall with DATA_W=1 and DATA_W=72 → output sequence equals input sequence, out_data is stable whenever out_valid & ~xfer, and in_ready never falls combinationally within a cycle.
